// File: rtl/hwpf_pkg.sv
// Shared types and helpers for the next-line prefetch issuer.
package hwpf_pkg;

  localparam int unsigned ADDR_W = 40;

  typedef logic [ADDR_W-1:0] addr_t;

  localparam int unsigned LANE_SIZE_DEFAULT   = 64;
  localparam logic [6:0]  PF_TID_BASE_DEFAULT = 7'h70;

  typedef struct packed {
    logic  valid;
    addr_t line;
  } hwpf_slot_t;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } hwpf_issuer_state_t;

  function automatic addr_t line_align(input addr_t addr, input int unsigned lane_size);
    addr_t mask;
    mask = addr_t'(lane_size - 1);
    return addr & ~mask;
  endfunction

endpackage

// File: rtl/hwpf_slot_table.sv
// In-flight prefetch slot storage: lowest-free allocation, line match,
// TID-based retire and occupancy count, all from registered state.
module hwpf_slot_table
  import hwpf_pkg::*;
#(
  parameter int unsigned          MAX_INFLIGHT = 4,
  parameter int unsigned          TID_WIDTH    = 7,
  parameter logic [TID_WIDTH-1:0] PF_TID_BASE  = TID_WIDTH'(PF_TID_BASE_DEFAULT),
  localparam int unsigned         SLOT_W       = $clog2(MAX_INFLIGHT)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 alloc_i,
  input  addr_t                alloc_line_i,
  input  logic                 release_i,
  input  logic [SLOT_W-1:0]    release_slot_i,
  input  logic                 resp_valid_i,
  input  logic [TID_WIDTH-1:0] resp_tid_i,
  input  addr_t                match_line_i,
  output logic                 match_o,
  output logic                 free_avail_o,
  output logic [SLOT_W-1:0]    free_slot_o,
  output logic [SLOT_W:0]      inflight_o
);

  logic [MAX_INFLIGHT-1:0] valid_q, valid_d;
  addr_t                   line_q [MAX_INFLIGHT];
  addr_t                   line_d [MAX_INFLIGHT];
  hwpf_slot_t              slot   [MAX_INFLIGHT];
  logic [TID_WIDTH-1:0]    resp_off;
  logic                    resp_hit;

  always_comb begin
    for (int s = 0; s < int'(MAX_INFLIGHT); s++) begin
      slot[s].valid = valid_q[s];
      slot[s].line  = line_q[s];
    end
  end

  // Descending scan so the lowest free index is the one left standing.
  always_comb begin
    match_o      = 1'b0;
    free_avail_o = 1'b0;
    free_slot_o  = '0;
    for (int s = int'(MAX_INFLIGHT) - 1; s >= 0; s--) begin
      if (slot[s].valid && (slot[s].line == match_line_i)) match_o = 1'b1;
      if (!slot[s].valid) begin
        free_avail_o = 1'b1;
        free_slot_o  = SLOT_W'(s);
      end
    end
  end

  always_comb begin
    inflight_o = '0;
    for (int s = 0; s < int'(MAX_INFLIGHT); s++) begin
      inflight_o = inflight_o + (SLOT_W + 1)'(valid_q[s]);
    end
  end

  // Wrapping subtraction turns the TID range check into one compare.
  assign resp_off = resp_tid_i - PF_TID_BASE;
  assign resp_hit = resp_valid_i && (resp_off < TID_WIDTH'(MAX_INFLIGHT));

  always_comb begin
    valid_d = valid_q;
    line_d  = line_q;
    if (resp_hit)  valid_d[resp_off[SLOT_W-1:0]] = 1'b0;
    if (release_i) valid_d[release_slot_i] = 1'b0;
    if (alloc_i && free_avail_o) begin
      valid_d[free_slot_o] = 1'b1;
      line_d[free_slot_o]  = alloc_line_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) valid_q <= '0;
    else         valid_q <= valid_d;
  end

  always_ff @(posedge clk_i) begin
    line_q <= line_d;
  end

endmodule

// File: rtl/hwpf_issuer.sv
// Prefetch queue consumer: pops line addresses, drops in-flight duplicates
// and issues the rest to the L1D port in cycles the demand path leaves idle.
module hwpf_issuer
  import hwpf_pkg::*;
#(
  parameter int unsigned          LANE_SIZE    = LANE_SIZE_DEFAULT,
  parameter int unsigned          MAX_INFLIGHT = 4,
  parameter type                  cpu_addr_t   = hwpf_pkg::addr_t,
  parameter int unsigned          TID_WIDTH    = 7,
  parameter logic [TID_WIDTH-1:0] PF_TID_BASE  = TID_WIDTH'(PF_TID_BASE_DEFAULT),
  localparam int unsigned         SLOT_W       = $clog2(MAX_INFLIGHT)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 fifo_valid_i,
  input  cpu_addr_t            fifo_addr_i,
  output logic                 fifo_read_o,
  input  logic                 cpu_req_valid_i,
  input  logic                 dcache_ready_i,
  output logic                 pf_req_valid_o,
  output cpu_addr_t            pf_req_addr_o,
  output logic [TID_WIDTH-1:0] pf_req_tid_o,
  input  logic                 dcache_resp_valid_i,
  input  logic [TID_WIDTH-1:0] dcache_resp_tid_i,
  output logic [SLOT_W:0]      inflight_o,
  output logic [15:0]          drop_cnt_o
);

  hwpf_issuer_state_t state_q, state_d;
  cpu_addr_t          hold_addr_q, hold_addr_d;
  logic [SLOT_W-1:0]  hold_slot_q, hold_slot_d;
  logic [15:0]        drop_cnt_q, drop_cnt_d;

  addr_t             head_line;
  logic              head_match;
  logic              free_avail;
  logic [SLOT_W-1:0] free_slot;
  logic              alloc;
  logic              release_held;
  logic              accept;

  assign head_line = line_align(addr_t'(fifo_addr_i), LANE_SIZE);
  assign accept    = dcache_ready_i && !cpu_req_valid_i;

  hwpf_slot_table #(
    .MAX_INFLIGHT (MAX_INFLIGHT),
    .TID_WIDTH    (TID_WIDTH),
    .PF_TID_BASE  (PF_TID_BASE)
  ) u_slot_table (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .alloc_i        (alloc),
    .alloc_line_i   (head_line),
    .release_i      (release_held),
    .release_slot_i (hold_slot_q),
    .resp_valid_i   (dcache_resp_valid_i),
    .resp_tid_i     (dcache_resp_tid_i),
    .match_line_i   (head_line),
    .match_o        (head_match),
    .free_avail_o   (free_avail),
    .free_slot_o    (free_slot),
    .inflight_o     (inflight_o)
  );

  always_comb begin
    state_d        = state_q;
    hold_addr_d    = hold_addr_q;
    hold_slot_d    = hold_slot_q;
    drop_cnt_d     = drop_cnt_q;
    fifo_read_o    = 1'b0;
    alloc          = 1'b0;
    release_held   = 1'b0;
    pf_req_valid_o = 1'b0;
    pf_req_addr_o  = '0;
    pf_req_tid_o   = '0;
    unique case (state_q)
      IDLE: begin
        if (!flush_i && fifo_valid_i) begin
          if (head_match) begin
            fifo_read_o = 1'b1;
            drop_cnt_d  = drop_cnt_q + 16'd1;
          end else if (free_avail) begin
            fifo_read_o = 1'b1;
            alloc       = 1'b1;
            hold_addr_d = cpu_addr_t'(head_line);
            hold_slot_d = free_slot;
            state_d     = REQ;
          end
        end
      end
      REQ: begin
        pf_req_valid_o = 1'b1;
        pf_req_addr_o  = hold_addr_q;
        pf_req_tid_o   = PF_TID_BASE + TID_WIDTH'(hold_slot_q);
        // A request the cache took in the flush cycle is still in flight.
        if (flush_i) begin
          state_d      = IDLE;
          release_held = !accept;
        end else if (accept) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign drop_cnt_o = drop_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    hold_addr_q <= hold_addr_d;
    hold_slot_q <= hold_slot_d;
  end

endmodule

// File: tb/tb_hwpf_issuer.sv
// Bench for hwpf_issuer: directed vector table, hand-written corner
// sequences and a randomized run against a behavioural model.
module tb_hwpf_issuer;

  typedef hwpf_pkg::addr_t addr_t;

  typedef struct {
    logic        fv;
    addr_t       addr;
    logic        cpu;
    logic        rdy;
    logic        rv;
    logic [6:0]  rtid;
    logic        fl;
    logic        rd;
    logic        pv;
    addr_t       paddr;
    logic [6:0]  ptid;
    logic [2:0]  inf;
    logic [15:0] drop;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_i = 1'b0;
  logic        fifo_valid_i = 1'b0;
  addr_t       fifo_addr_i = '0;
  logic        fifo_read_o;
  logic        cpu_req_valid_i = 1'b0;
  logic        dcache_ready_i = 1'b0;
  logic        pf_req_valid_o;
  addr_t       pf_req_addr_o;
  logic [6:0]  pf_req_tid_o;
  logic        dcache_resp_valid_i = 1'b0;
  logic [6:0]  dcache_resp_tid_i = '0;
  logic [2:0]  inflight_o;
  logic [15:0] drop_cnt_o;

  int checks = 0;
  int errors = 0;
  vec_t vt[$];

  always #5 clk = ~clk;

  hwpf_issuer dut (
    .clk_i               (clk),
    .rst_ni              (rst_ni),
    .flush_i             (flush_i),
    .fifo_valid_i        (fifo_valid_i),
    .fifo_addr_i         (fifo_addr_i),
    .fifo_read_o         (fifo_read_o),
    .cpu_req_valid_i     (cpu_req_valid_i),
    .dcache_ready_i      (dcache_ready_i),
    .pf_req_valid_o      (pf_req_valid_o),
    .pf_req_addr_o       (pf_req_addr_o),
    .pf_req_tid_o        (pf_req_tid_o),
    .dcache_resp_valid_i (dcache_resp_valid_i),
    .dcache_resp_tid_i   (dcache_resp_tid_i),
    .inflight_o          (inflight_o),
    .drop_cnt_o          (drop_cnt_o)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required finish before 500000");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic fv, input addr_t addr, input logic cpu, input logic rdy,
                              input logic rv, input logic [6:0] rtid, input logic fl,
                              input logic rd, input logic pv, input addr_t paddr,
                              input logic [6:0] ptid, input logic [2:0] inf, input logic [15:0] drop);
    vec_t v;
    v.fv = fv; v.addr = addr; v.cpu = cpu; v.rdy = rdy; v.rv = rv; v.rtid = rtid; v.fl = fl;
    v.rd = rd; v.pv = pv; v.paddr = paddr; v.ptid = ptid; v.inf = inf; v.drop = drop;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 50) $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fv, input addr_t addr, input logic cpu, input logic rdy,
                       input logic rv, input logic [6:0] rtid, input logic fl);
    fifo_valid_i = fv; fifo_addr_i = addr; cpu_req_valid_i = cpu; dcache_ready_i = rdy;
    dcache_resp_valid_i = rv; dcache_resp_tid_i = rtid; flush_i = fl;
  endtask

  task automatic check_outs(input string name, input logic rd, input logic pv, input addr_t paddr,
                            input logic [6:0] ptid, input logic [2:0] inf, input logic [15:0] drop);
    chk({name, "_read"}, 64'(fifo_read_o), 64'(rd));
    chk({name, "_valid"}, 64'(pf_req_valid_o), 64'(pv));
    chk({name, "_addr"}, 64'(pf_req_addr_o), 64'(paddr));
    chk({name, "_tid"}, 64'(pf_req_tid_o), 64'(ptid));
    chk({name, "_inflight"}, 64'(inflight_o), 64'(inf));
    chk({name, "_drop"}, 64'(drop_cnt_o), 64'(drop));
  endtask

  // Drive one cycle of inputs, check outputs before the edge, then advance.
  task automatic step(input string name, input vec_t v);
    drive(v.fv, v.addr, v.cpu, v.rdy, v.rv, v.rtid, v.fl);
    #1;
    check_outs(name, v.rd, v.pv, v.paddr, v.ptid, v.inf, v.drop);
    @(posedge clk);
    #1;
  endtask

  // Behavioural model state for the randomized phase.
  bit          m_busy;
  addr_t       m_hold;
  int          m_slot;
  bit          m_valid [4];
  addr_t       m_line  [4];
  logic [15:0] m_drop;

  function automatic addr_t align64(input addr_t a);
    return (a / 64) * 64;
  endfunction

  task automatic random_phase(input int n);
    addr_t head;
    head = 40'h8000 + 40'(64 * $urandom_range(0, 7)) + 40'($urandom_range(0, 63));
    m_busy = 0; m_hold = '0; m_slot = 0; m_drop = '0;
    for (int s = 0; s < 4; s++) begin m_valid[s] = 0; m_line[s] = '0; end
    for (int c = 0; c < n; c++) begin
      logic fv, cpu, rdy, rv, fl, acc, match, e_rd;
      logic [6:0] rtid;
      addr_t al;
      int fre, cnt, alloc;
      fv   = ($urandom % 10) < 7;
      cpu  = ($urandom % 10) < 3;
      rdy  = ($urandom % 10) < 7;
      rv   = ($urandom % 10) < 3;
      rtid = (($urandom % 10) < 7) ? 7'(7'h70 + ($urandom % 4)) : 7'($urandom % 128);
      fl   = ($urandom % 100) < 3;
      drive(fv, head, cpu, rdy, rv, rtid, fl);
      #1;
      al = align64(head);
      match = 0; fre = -1; cnt = 0;
      for (int s = 3; s >= 0; s--) begin
        if (m_valid[s]) begin cnt++; if (m_line[s] == al) match = 1; end
        else fre = s;
      end
      e_rd = !m_busy && !fl && fv && (match || fre >= 0);
      check_outs("rand", e_rd, m_busy, m_busy ? m_hold : '0,
                 m_busy ? 7'(7'h70 + m_slot) : 7'h0, 3'(cnt), m_drop);
      acc = m_busy && rdy && !cpu;
      alloc = -1;
      if (!m_busy) begin
        if (!fl && fv) begin
          if (match) m_drop = m_drop + 16'd1;
          else if (fre >= 0) begin alloc = fre; m_hold = al; m_slot = fre; m_busy = 1; end
        end
      end else begin
        if (fl) begin
          if (!acc) m_valid[m_slot] = 0;
          m_busy = 0;
        end else if (acc) m_busy = 0;
      end
      if (rv && rtid >= 7'h70 && rtid < 7'h74) m_valid[rtid - 7'h70] = 0;
      if (alloc >= 0) begin m_valid[alloc] = 1; m_line[alloc] = al; end
      @(posedge clk);
      #1;
      if (e_rd || !fv)
        head = 40'h8000 + 40'(64 * $urandom_range(0, 7)) + 40'($urandom_range(0, 63));
    end
  endtask

  initial begin
    // Reset state
    drive(0, '0, 0, 1, 0, '0, 0);
    @(posedge clk); #1;
    check_outs("reset", 0, 0, '0, '0, 0, 0);
    rst_ni = 1'b1;

    // Single issue, demand priority, duplicate drop
    vt.push_back(mk(1, 40'h1000_0044, 0, 1, 0, 7'h00, 0, 1, 0, 40'h0,         7'h00, 0, 0));
    vt.push_back(mk(0, 40'h0,         0, 1, 0, 7'h00, 0, 0, 1, 40'h1000_0040, 7'h70, 1, 0));
    vt.push_back(mk(0, 40'h0,         0, 1, 1, 7'h70, 0, 0, 0, 40'h0,         7'h00, 1, 0));
    vt.push_back(mk(0, 40'h0,         0, 1, 0, 7'h00, 0, 0, 0, 40'h0,         7'h00, 0, 0));
    vt.push_back(mk(1, 40'h3000_0008, 0, 1, 0, 7'h00, 0, 1, 0, 40'h0,         7'h00, 0, 0));
    for (int i = 0; i < 5; i++)
      vt.push_back(mk(0, 40'h0,       1, 1, 0, 7'h00, 0, 0, 1, 40'h3000_0000, 7'h70, 1, 0));
    vt.push_back(mk(0, 40'h0,         0, 1, 0, 7'h00, 0, 0, 1, 40'h3000_0000, 7'h70, 1, 0));
    vt.push_back(mk(0, 40'h0,         0, 1, 1, 7'h70, 0, 0, 0, 40'h0,         7'h00, 1, 0));
    vt.push_back(mk(1, 40'h2000,      0, 1, 0, 7'h00, 0, 1, 0, 40'h0,         7'h00, 0, 0));
    vt.push_back(mk(1, 40'h2010,      0, 1, 0, 7'h00, 0, 0, 1, 40'h2000,      7'h70, 1, 0));
    vt.push_back(mk(1, 40'h2010,      0, 1, 0, 7'h00, 0, 1, 0, 40'h0,         7'h00, 1, 0));
    vt.push_back(mk(0, 40'h0,         0, 1, 0, 7'h00, 0, 0, 0, 40'h0,         7'h00, 1, 1));
    vt.push_back(mk(0, 40'h0,         0, 1, 1, 7'h70, 0, 0, 0, 40'h0,         7'h00, 1, 1));
    vt.push_back(mk(1, 40'h2000,      0, 1, 0, 7'h00, 0, 1, 0, 40'h0,         7'h00, 0, 1));
    vt.push_back(mk(0, 40'h0,         0, 1, 0, 7'h00, 0, 0, 1, 40'h2000,      7'h70, 1, 1));
    vt.push_back(mk(0, 40'h0,         0, 1, 1, 7'h70, 0, 0, 0, 40'h0,         7'h00, 1, 1));
    vt.push_back(mk(0, 40'h0,         0, 1, 0, 7'h00, 0, 0, 0, 40'h0,         7'h00, 0, 1));
    foreach (vt[i]) step($sformatf("vec%0d", i), vt[i]);

    // Full table, then retire of slot 2 frees exactly that slot
    for (int i = 0; i < 4; i++) begin
      step("full_pop", mk(1, 40'(40'h4004 + 64 * i), 0, 1, 0, 7'h00, 0, 1, 0, 40'h0, 7'h00, 3'(i), 1));
      step("full_req", mk(0, 40'h0, 0, 1, 0, 7'h00, 0, 0, 1, 40'(40'h4000 + 64 * i), 7'(7'h70 + i), 3'(i + 1), 1));
    end
    step("full_stall0", mk(1, 40'h5000, 0, 1, 0, 7'h00, 0, 0, 0, 40'h0, 7'h00, 4, 1));
    step("full_stall1", mk(1, 40'h5000, 0, 1, 0, 7'h00, 0, 0, 0, 40'h0, 7'h00, 4, 1));
    step("full_resp",   mk(1, 40'h5000, 0, 1, 1, 7'h72, 0, 0, 0, 40'h0, 7'h00, 4, 1));
    step("full_pop5",   mk(1, 40'h5000, 0, 1, 0, 7'h00, 0, 1, 0, 40'h0, 7'h00, 3, 1));
    step("full_req5",   mk(0, 40'h0,    0, 1, 0, 7'h00, 0, 0, 1, 40'h5000, 7'h72, 4, 1));
    for (int i = 0; i < 4; i++)
      step("full_drain", mk(0, 40'h0, 0, 1, 1, 7'(7'h70 + i), 0, 0, 0, 40'h0, 7'h00, 3'(4 - i), 1));
    step("full_empty", mk(0, 40'h0, 0, 1, 0, 7'h00, 0, 0, 0, 40'h0, 7'h00, 0, 1));

    // Flush while the request is stalled by the cache
    step("fl_popA",  mk(1, 40'h6000, 0, 1, 0, 7'h00, 0, 1, 0, 40'h0,    7'h00, 0, 1));
    step("fl_reqA",  mk(0, 40'h0,    0, 1, 0, 7'h00, 0, 0, 1, 40'h6000, 7'h70, 1, 1));
    step("fl_popB",  mk(1, 40'h6040, 0, 0, 0, 7'h00, 0, 1, 0, 40'h0,    7'h00, 1, 1));
    step("fl_stall", mk(0, 40'h0,    0, 0, 0, 7'h00, 0, 0, 1, 40'h6040, 7'h71, 2, 1));
    step("fl_flush", mk(1, 40'h6040, 0, 0, 0, 7'h00, 1, 0, 1, 40'h6040, 7'h71, 2, 1));
    step("fl_idle",  mk(1, 40'h6040, 0, 1, 0, 7'h00, 1, 0, 0, 40'h0,    7'h00, 1, 1));
    step("fl_repop", mk(1, 40'h6040, 0, 1, 0, 7'h00, 0, 1, 0, 40'h0,    7'h00, 1, 1));
    step("fl_rereq", mk(0, 40'h0,    0, 1, 0, 7'h00, 0, 0, 1, 40'h6040, 7'h71, 2, 1));
    step("fl_r70",   mk(0, 40'h0,    0, 1, 1, 7'h70, 0, 0, 0, 40'h0,    7'h00, 2, 1));
    step("fl_r71",   mk(0, 40'h0,    0, 1, 1, 7'h71, 0, 0, 0, 40'h0,    7'h00, 1, 1));
    step("fl_empty", mk(0, 40'h0,    0, 1, 0, 7'h00, 0, 0, 0, 40'h0,    7'h00, 0, 1));

    // Foreign responses leave slot 0 live and matching
    step("fr_pop",  mk(1, 40'h7000, 0, 1, 0, 7'h00, 0, 1, 0, 40'h0,    7'h00, 0, 1));
    step("fr_req",  mk(0, 40'h0,    0, 1, 0, 7'h00, 0, 0, 1, 40'h7000, 7'h70, 1, 1));
    step("fr_t05",  mk(0, 40'h0,    0, 1, 1, 7'h05, 0, 0, 0, 40'h0,    7'h00, 1, 1));
    step("fr_t71",  mk(0, 40'h0,    0, 1, 1, 7'h71, 0, 0, 0, 40'h0,    7'h00, 1, 1));
    step("fr_dup",  mk(1, 40'h7010, 0, 1, 0, 7'h00, 0, 1, 0, 40'h0,    7'h00, 1, 1));
    step("fr_t74",  mk(0, 40'h0,    0, 1, 1, 7'h74, 0, 0, 0, 40'h0,    7'h00, 1, 2));
    step("fr_popB", mk(1, 40'h7040, 0, 0, 0, 7'h00, 0, 1, 0, 40'h0,    7'h00, 1, 2));

    // Asynchronous reset in the middle of a stalled request
    drive(0, '0, 0, 0, 0, '0, 0);
    #1;
    check_outs("rst_pre", 0, 1, 40'h7040, 7'h71, 2, 2);
    rst_ni = 1'b0;
    #1;
    check_outs("rst_async", 0, 0, '0, '0, 0, 0);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    step("rst_after", mk(0, 40'h0, 0, 1, 0, 7'h00, 0, 0, 0, 40'h0, 7'h00, 0, 0));

    random_phase(3000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
